// File: rtl/receiver_pkg.sv
// receiver_pkg: shared RX slot definitions.
// Header offsets mirror the TX slot so host code reads both alike.
package receiver_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_PREAMBLE,
    RX_DATA,
    RX_HDR_WRITE,
    RX_DISCARD
  } rx_state_t;

  localparam int HDR_WORDS = 7;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

  localparam logic [2:0] HDR_LEN     = 3'd0;
  localparam logic [2:0] HDR_TS3     = 3'd1;
  localparam logic [2:0] HDR_TS2     = 3'd2;
  localparam logic [2:0] HDR_TS1     = 3'd3;
  localparam logic [2:0] HDR_TS0     = 3'd4;
  localparam logic [2:0] HDR_HASH_HI = 3'd5;
  localparam logic [2:0] HDR_HASH_LO = 3'd6;

  function automatic logic [31:0] crc32_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ CRC_POLY_REFL) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/receiver_fcs.sv
// rx_fcs_check: running reflected CRC-32 over DA..FCS.
// crc_ok reflects every byte accepted up to the previous edge.
module rx_fcs_check
  import receiver_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       data_en,
  input  logic [7:0] data,
  output logic       crc_ok
);

  logic [31:0] crc;

  always_ff @(posedge clk) begin
    if (!rst_n)
      crc <= 32'hFFFF_FFFF;
    else if (init)
      crc <= 32'hFFFF_FFFF;
    else if (data_en)
      crc <= crc32_byte(crc, data);
  end

  assign crc_ok = (crc == CRC_RESIDUE);

endmodule

// File: rtl/receiver.sv
// receiver: GMII RX frame capture into the RX slot RAM.
// Payload lands as it arrives; the slot is published only after its header.
module receiver
  import receiver_pkg::*;
#(
  parameter int MIN_FRAME_LEN = 60,
  parameter int MAX_FRAME_LEN = 1514
) (
  input  logic        gmii_rx_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] global_counter,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [15:0] slot_rx_eth_data,
  output logic [1:0]  slot_rx_eth_byte_en,
  output logic [13:0] slot_rx_eth_addr,
  output logic        slot_rx_eth_wr_en,
  input  logic [13:0] mem_rd_ptr,
  output logic [13:0] mem_wr_ptr,
  output logic [31:0] rx_good_count,
  output logic [31:0] rx_drop_count
);

  localparam int SPACE_NEED =
    HDR_WORDS + (MAX_FRAME_LEN + 5) / 2;

  rx_state_t   state, state_d;
  logic [63:0] ts, ts_d;
  logic [13:0] base, base_d;
  logic [13:0] wptr, wptr_d;
  logic [13:0] ptr_d, addr_d, free;
  logic [15:0] cnt, cnt_d;
  logic [15:0] len, len_d;
  logic [15:0] len_v, half;
  logic [15:0] data_d, hdr_word;
  logic [7:0]  hi, hi_d;
  logic [31:0] fcs, fcs_d;
  logic [31:0] good_d, drop_d;
  logic [2:0]  idx, idx_d;
  logic [1:0]  be_d;
  logic        wr_d, crc_init, crc_en, crc_ok;

  assign free   = mem_rd_ptr - mem_wr_ptr - 14'd1;
  assign crc_en = (state == RX_DATA) && gmii_rx_dv;
  assign len_v  = cnt - 16'd4;
  assign half   = (len + 16'd1) >> 1;

  rx_fcs_check u_fcs (
    .clk     (gmii_rx_clk),
    .rst_n   (sys_rst_n),
    .init    (crc_init),
    .data_en (crc_en),
    .data    (gmii_rxd),
    .crc_ok  (crc_ok)
  );

  always_comb begin
    unique case (idx)
      HDR_LEN:     hdr_word = len;
      HDR_TS3:     hdr_word = ts[63:48];
      HDR_TS2:     hdr_word = ts[47:32];
      HDR_TS1:     hdr_word = ts[31:16];
      HDR_TS0:     hdr_word = ts[15:0];
      HDR_HASH_HI: hdr_word = fcs[31:16];
      HDR_HASH_LO: hdr_word = fcs[15:0];
      default:     hdr_word = '0;
    endcase
  end

  always_comb begin
    state_d  = state;
    ts_d     = ts;
    base_d   = base;
    wptr_d   = wptr;
    cnt_d    = cnt;
    hi_d     = hi;
    fcs_d    = fcs;
    len_d    = len;
    idx_d    = idx;
    ptr_d    = mem_wr_ptr;
    good_d   = rx_good_count;
    drop_d   = rx_drop_count;
    wr_d     = 1'b0;
    addr_d   = '0;
    data_d   = '0;
    be_d     = '0;
    crc_init = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (gmii_rx_dv && gmii_rxd == PREAMBLE_BYTE)
          state_d = RX_PREAMBLE;
      end
      RX_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = RX_IDLE;
        end else if (gmii_rxd == SFD_BYTE) begin
          ts_d     = global_counter;
          base_d   = mem_wr_ptr;
          wptr_d   = mem_wr_ptr + 14'(HDR_WORDS);
          cnt_d    = '0;
          crc_init = 1'b1;
          if (free < 14'(SPACE_NEED)) begin
            state_d = RX_DISCARD;
            drop_d  = sat_inc(rx_drop_count);
          end else begin
            state_d = RX_DATA;
          end
        end else if (gmii_rxd != PREAMBLE_BYTE) begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (gmii_rx_dv) begin
          if (gmii_rx_er || cnt >= 16'(MAX_FRAME_LEN + 4)) begin
            state_d = RX_DISCARD;
            drop_d  = sat_inc(rx_drop_count);
          end else begin
            cnt_d = cnt + 16'd1;
            fcs_d = {fcs[23:0], gmii_rxd};
            if (!cnt[0]) begin
              hi_d = gmii_rxd;
            end else begin
              wr_d   = 1'b1;
              addr_d = wptr;
              data_d = {hi, gmii_rxd};
              be_d   = 2'b11;
              wptr_d = wptr + 14'd1;
            end
          end
        end else begin
          if (cnt[0]) begin
            wr_d   = 1'b1;
            addr_d = wptr;
            data_d = {hi, 8'h00};
            be_d   = 2'b10;
          end
          if (crc_ok && len_v >= 16'(MIN_FRAME_LEN) &&
              len_v <= 16'(MAX_FRAME_LEN)) begin
            len_d   = len_v;
            idx_d   = '0;
            state_d = RX_HDR_WRITE;
          end else begin
            drop_d  = sat_inc(rx_drop_count);
            state_d = RX_IDLE;
          end
        end
      end
      RX_HDR_WRITE: begin
        if (idx == 3'd7) begin
          ptr_d   = base + 14'(HDR_WORDS) + half[13:0];
          good_d  = sat_inc(rx_good_count);
          state_d = RX_IDLE;
        end else begin
          wr_d   = 1'b1;
          addr_d = base + 14'(idx);
          data_d = hdr_word;
          be_d   = 2'b11;
          idx_d  = idx + 3'd1;
        end
      end
      RX_DISCARD: begin
        if (!gmii_rx_dv)
          state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (!sys_rst_n) begin
      state               <= RX_IDLE;
      ts                  <= '0;
      base                <= '0;
      wptr                <= '0;
      cnt                 <= '0;
      hi                  <= '0;
      fcs                 <= '0;
      len                 <= '0;
      idx                 <= '0;
      mem_wr_ptr          <= '0;
      rx_good_count       <= '0;
      rx_drop_count       <= '0;
      slot_rx_eth_wr_en   <= 1'b0;
      slot_rx_eth_addr    <= '0;
      slot_rx_eth_data    <= '0;
      slot_rx_eth_byte_en <= '0;
    end else begin
      state               <= state_d;
      ts                  <= ts_d;
      base                <= base_d;
      wptr                <= wptr_d;
      cnt                 <= cnt_d;
      hi                  <= hi_d;
      fcs                 <= fcs_d;
      len                 <= len_d;
      idx                 <= idx_d;
      mem_wr_ptr          <= ptr_d;
      rx_good_count       <= good_d;
      rx_drop_count       <= drop_d;
      slot_rx_eth_wr_en   <= wr_d;
      slot_rx_eth_addr    <= addr_d;
      slot_rx_eth_data    <= data_d;
      slot_rx_eth_byte_en <= be_d;
    end
  end

endmodule
